// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared state codes and decode helpers for the multicycle MIPS control path.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    localparam int STATE_W = 7;

    // Fetch / trap sequence
    localparam logic [STATE_W-1:0] S_TRAP    = 7'd0;
    localparam logic [STATE_W-1:0] S_FETCH0  = 7'd1;
    localparam logic [STATE_W-1:0] S_FETCH1  = 7'd2;
    localparam logic [STATE_W-1:0] S_FETCH2  = 7'd3;
    localparam logic [STATE_W-1:0] S_DECODE  = 7'd4;

    // Store, branch and load sequences
    localparam logic [STATE_W-1:0] S_ST_ADDR = 7'd7;
    localparam logic [STATE_W-1:0] S_ST_DATA = 7'd8;
    localparam logic [STATE_W-1:0] S_ST_WAIT = 7'd9;
    localparam logic [STATE_W-1:0] S_BEQ     = 7'd11;
    localparam logic [STATE_W-1:0] S_BR_TAKE = 7'd12;
    localparam logic [STATE_W-1:0] S_LD_ADDR = 7'd13;
    localparam logic [STATE_W-1:0] S_LD_WAIT = 7'd14;
    localparam logic [STATE_W-1:0] S_LD_WB   = 7'd15;

    // Single-cycle ALU write-back states: ADDU plus the contiguous block SUBU..LUI
    localparam logic [STATE_W-1:0] S_ADDU    = 7'd6;
    localparam logic [STATE_W-1:0] S_SUBU    = 7'd17;
    localparam logic [STATE_W-1:0] S_AND     = 7'd18;
    localparam logic [STATE_W-1:0] S_OR      = 7'd19;
    localparam logic [STATE_W-1:0] S_XOR     = 7'd20;
    localparam logic [STATE_W-1:0] S_NOR     = 7'd21;
    localparam logic [STATE_W-1:0] S_SLT     = 7'd22;
    localparam logic [STATE_W-1:0] S_SLTU    = 7'd23;
    localparam logic [STATE_W-1:0] S_SLL     = 7'd24;
    localparam logic [STATE_W-1:0] S_SRL     = 7'd25;
    localparam logic [STATE_W-1:0] S_SRA     = 7'd26;
    localparam logic [STATE_W-1:0] S_ADDIU   = 7'd27;
    localparam logic [STATE_W-1:0] S_ANDI    = 7'd28;
    localparam logic [STATE_W-1:0] S_ORI     = 7'd29;
    localparam logic [STATE_W-1:0] S_LUI     = 7'd30;

    function automatic logic is_alu(logic [STATE_W-1:0] s);
        return (s == S_ADDU) || ((s >= S_SUBU) && (s <= S_LUI));
    endfunction

    // Codes DECODE may branch to; everything else is an illegal instruction.
    function automatic logic is_decode_target(logic [STATE_W-1:0] s);
        return is_alu(s) || (s == S_ST_ADDR) || (s == S_BEQ) || (s == S_LD_ADDR);
    endfunction

    // States that hold the memory bus waiting for MOC.
    function automatic logic is_wait(logic [STATE_W-1:0] s);
        return (s == S_FETCH1) || (s == S_ST_WAIT) || (s == S_LD_WAIT);
    endfunction

endpackage

// File: rtl/moc_timeout_ctr.sv
// Purpose: counts memory wait cycles without MOC; flags when the bound is reached.
// Latency: count updates one cycle after enable; expired is combinational on count.
// Backpressure: none; holds at the bound until cleared.
// Ports: core_clk, arst_n (async active-low), clear (sync zero), enable (count one),
//        count (current wait count), expired (count == MOC_TIMEOUT).
module moc_timeout_ctr #(
    parameter int TO_W        = 8,
    parameter int MOC_TIMEOUT = 255
) (
    input  logic            core_clk,
    input  logic            arst_n,
    input  logic            clear,
    input  logic            enable,
    output logic [TO_W-1:0] count,
    output logic            expired
);

    assign expired = (count == TO_W'(MOC_TIMEOUT));

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TO_W'(1);
        end
    end

endmodule

// File: rtl/control_state_sequencer.sv
// Purpose: multicycle MIPS control FSM sequencing fetch/decode/execute with bounded memory waits.
// Latency: one state per Clk; strobes decode from State in the same cycle; trap pulses lag by one.
// Backpressure: wait states hold until MOC, or trap to state 0 after MOC_TIMEOUT idle cycles.
// Ports: Clk, Reset_n (async active-low); State_Sel (sampled in DECODE), MOC (sampled in waits),
//        Cond (sampled in BEQ); State, PC/IR/MAR/MDR/RF load strobes, MOV/RW memory request,
//        Illegal_Instr and Bus_Error one-cycle trap pulses.
module control_state_sequencer #(
    parameter int STATE_W     = 7,
    parameter int MOC_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [STATE_W-1:0] State_Sel,
    input  logic               MOC,
    input  logic               Cond,
    output logic [STATE_W-1:0] State,
    output logic               PC_Ld,
    output logic               IR_Ld,
    output logic               MAR_Ld,
    output logic               MDR_Ld,
    output logic               RF_Ld,
    output logic               MOV,
    output logic               RW,
    output logic               Illegal_Instr,
    output logic               Bus_Error
);

    import cpu_ctrl_pkg::*;

    logic [STATE_W-1:0] state_nxt;
    logic               illegal_nxt;
    logic               bus_error_nxt;
    logic               in_wait;
    logic               to_expired;
    logic [TO_W-1:0]    wait_cnt;

    assign in_wait = is_wait(State);

    // Counter idles at zero outside wait states, so every wait entry starts from zero.
    moc_timeout_ctr #(
        .TO_W        (TO_W),
        .MOC_TIMEOUT (MOC_TIMEOUT)
    ) u_moc_timeout_ctr (
        .core_clk (Clk),
        .arst_n   (Reset_n),
        .clear    (!in_wait),
        .enable   (in_wait && !MOC),
        .count    (wait_cnt),
        .expired  (to_expired)
    );

    // Next-state logic. MOC is checked before expiry so a late completion still wins.
    always_comb begin
        state_nxt     = S_TRAP;
        illegal_nxt   = 1'b0;
        bus_error_nxt = 1'b0;
        case (State)
            S_TRAP:    state_nxt = S_FETCH0;
            S_FETCH0:  state_nxt = S_FETCH1;
            S_FETCH1: begin
                if (MOC)             state_nxt = S_FETCH2;
                else if (to_expired) bus_error_nxt = 1'b1;
                else                 state_nxt = S_FETCH1;
            end
            S_FETCH2:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_decode_target(State_Sel)) state_nxt = State_Sel;
                else                             illegal_nxt = 1'b1;
            end
            S_ST_ADDR: state_nxt = S_ST_DATA;
            S_ST_DATA: state_nxt = S_ST_WAIT;
            S_ST_WAIT: begin
                if (MOC)             state_nxt = S_FETCH0;
                else if (to_expired) bus_error_nxt = 1'b1;
                else                 state_nxt = S_ST_WAIT;
            end
            S_BEQ:     state_nxt = Cond ? S_BR_TAKE : S_FETCH0;
            S_BR_TAKE: state_nxt = S_FETCH0;
            S_LD_ADDR: state_nxt = S_LD_WAIT;
            S_LD_WAIT: begin
                if (MOC)             state_nxt = S_LD_WB;
                else if (to_expired) bus_error_nxt = 1'b1;
                else                 state_nxt = S_LD_WAIT;
            end
            S_LD_WB:   state_nxt = S_FETCH0;
            // ALU write-back states return to fetch; unused codes fall to trap silently.
            default:   state_nxt = is_alu(State) ? S_FETCH0 : S_TRAP;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            State         <= S_TRAP;
            Illegal_Instr <= 1'b0;
            Bus_Error     <= 1'b0;
        end else begin
            State         <= state_nxt;
            Illegal_Instr <= illegal_nxt;
            Bus_Error     <= bus_error_nxt;
        end
    end

    // Moore strobes from State; MDR_Ld in LD_WAIT follows MOC so the data latches on completion.
    // RW idles at read so only ST_WAIT ever presents a write.
    always_comb begin
        PC_Ld  = 1'b0;
        IR_Ld  = 1'b0;
        MAR_Ld = 1'b0;
        MDR_Ld = 1'b0;
        RF_Ld  = 1'b0;
        MOV    = 1'b0;
        RW     = 1'b1;
        case (State)
            S_FETCH0:  MAR_Ld = 1'b1;
            S_FETCH1:  MOV    = 1'b1;
            S_FETCH2: begin
                IR_Ld = 1'b1;
                PC_Ld = 1'b1;
            end
            S_ST_ADDR: MAR_Ld = 1'b1;
            S_ST_DATA: MDR_Ld = 1'b1;
            S_ST_WAIT: begin
                MOV = 1'b1;
                RW  = 1'b0;
            end
            S_BR_TAKE: PC_Ld  = 1'b1;
            S_LD_ADDR: MAR_Ld = 1'b1;
            S_LD_WAIT: begin
                MOV    = 1'b1;
                MDR_Ld = MOC;
            end
            S_LD_WB:   RF_Ld  = 1'b1;
            default:   RF_Ld  = is_alu(State);
        endcase
    end

    // Wait counter must never run past the trap bound.
    a_wait_cnt_bound: assert property (@(posedge Clk) disable iff (!Reset_n)
        wait_cnt <= TO_W'(MOC_TIMEOUT));

endmodule

// File: tb/tb_control_state_sequencer.sv
module tb_control_state_sequencer;

    localparam int TO = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [6:0] State_Sel = '0;
    logic       MOC = 1'b0;
    logic       Cond = 1'b0;
    logic [6:0] State;
    logic       PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV, RW, Illegal_Instr, Bus_Error;

    control_state_sequencer #(.STATE_W(7), .MOC_TIMEOUT(TO), .TO_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .State_Sel(State_Sel), .MOC(MOC), .Cond(Cond),
        .State(State), .PC_Ld(PC_Ld), .IR_Ld(IR_Ld), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld),
        .RF_Ld(RF_Ld), .MOV(MOV), .RW(RW), .Illegal_Instr(Illegal_Instr), .Bus_Error(Bus_Error)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [6:0] st;
        logic pc, ir, mar, mdr, rf, mov, rw, ill, be;
    } rec_t;

    rec_t exp_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    function automatic bit is_alu_code(input int c);
        return (c == 6) || (c >= 17 && c <= 30);
    endfunction

    function automatic bit legal_code(input int c);
        return is_alu_code(c) || c == 7 || c == 11 || c == 13;
    endfunction

    // Strobe table straight from the state list: what each state must present.
    function automatic rec_t model(input int st, input bit moc, input bit ill, input bit be);
        rec_t r;
        r     = '0;
        r.st  = 7'(st);
        r.rw  = 1'b1;
        r.ill = ill;
        r.be  = be;
        if (st == 1 || st == 7 || st == 13) r.mar = 1'b1;
        if (st == 2 || st == 9 || st == 14) r.mov = 1'b1;
        if (st == 3) begin r.ir = 1'b1; r.pc = 1'b1; end
        if (st == 12) r.pc = 1'b1;
        if (st == 8) r.mdr = 1'b1;
        if (st == 14) r.mdr = moc;
        if (st == 9) r.rw = 1'b0;
        if (st == 15 || is_alu_code(st)) r.rf = 1'b1;
        return r;
    endfunction

    // Drive inputs for a cycle in which the DUT should sit in state st; inputs the
    // DUT must ignore in that state are randomised.
    task automatic drive(input int st, input bit moc, input bit cond, input int sel,
                         input bit ill = 1'b0, input bit be = 1'b0);
        MOC       = (st == 2 || st == 9 || st == 14) ? moc : 1'($urandom_range(0, 1));
        Cond      = (st == 11) ? cond : 1'($urandom_range(0, 1));
        State_Sel = (st == 4) ? 7'(sel) : 7'($urandom_range(0, 127));
        exp_q.push_back(model(st, MOC, ill, be));
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // n0 idle cycles then MOC; more than TO idle cycles ends in a bus-error trap.
    task automatic mem_wait(input int st, input int n0, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            if (i < n0) begin
                drive(st, 1'b0, 1'b0, 0); tick;
            end else begin
                drive(st, 1'b1, 1'b0, 0); tick;
                return;
            end
        end
        trapped = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b1); tick;
    endtask

    // One instruction from FETCH0 through its last state.
    task automatic run_instr(input int code, input bit cond, input int wf, input int wm);
        bit tr;
        drive(1, 1'b0, 1'b0, 0); tick;
        mem_wait(2, wf, tr);
        if (tr) return;
        drive(3, 1'b0, 1'b0, 0); tick;
        drive(4, 1'b0, 1'b0, code); tick;
        if (!legal_code(code)) begin
            drive(0, 1'b0, 1'b0, 0, 1'b1, 1'b0); tick;
        end else if (is_alu_code(code)) begin
            drive(code, 1'b0, 1'b0, 0); tick;
        end else if (code == 7) begin
            drive(7, 1'b0, 1'b0, 0); tick;
            drive(8, 1'b0, 1'b0, 0); tick;
            mem_wait(9, wm, tr);
        end else if (code == 11) begin
            drive(11, 1'b0, cond, 0); tick;
            if (cond) begin drive(12, 1'b0, 1'b0, 0); tick; end
        end else begin
            drive(13, 1'b0, 1'b0, 0); tick;
            mem_wait(14, wm, tr);
            if (!tr) begin drive(15, 1'b0, 1'b0, 0); tick; end
        end
    endtask

    // Monitor: compares every DUT cycle that has an expectation queued.
    initial begin
        rec_t e, a;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {State, PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV, RW, Illegal_Instr, Bus_Error};
                if (!e.mov) begin a.rw = 1'b0; e.rw = 1'b0; end
                check($sformatf("cycle_state%0d", e.st), 32'(a), 32'(e));
            end
        end
    end

    initial begin
        int code, r;
        bit cond;
        int wf, wm;
        int bad_codes[14] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 12, 14, 15, 16, 31};

        // Reset state while held
        #3;
        check("reset_state", 32'(State), 32'd0);
        check("reset_strobes", 32'({PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV}), 32'd0);
        check("reset_rw", 32'(RW), 32'd1);
        check("reset_traps", 32'({Illegal_Instr, Bus_Error}), 32'd0);
        #9 Reset_n = 1'b1;
        tick;

        // Directed scenarios
        run_instr(6, 1'b0, 0, 0);      // ADDU
        run_instr(7, 1'b0, 0, 3);      // SW with three idle wait cycles
        run_instr(11, 1'b1, 0, 0);     // BEQ taken
        run_instr(11, 1'b0, 0, 0);     // BEQ not taken
        run_instr(0, 1'b0, 0, 0);      // illegal State_Sel=0
        run_instr(127, 1'b0, 0, 0);    // unused code from DECODE
        run_instr(13, 1'b0, 0, TO + 1);// LW timeout
        run_instr(13, 1'b0, 0, TO);    // LW, MOC on expiry cycle wins
        run_instr(7, 1'b0, TO + 1, 0); // fetch timeout
        run_instr(30, 1'b0, TO, 0);    // LUI with fetch completing on expiry cycle

        // Async reset in the middle of FETCH1
        drive(1, 1'b0, 1'b0, 0); tick;
        drive(2, 1'b0, 1'b0, 0);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        check("midreset_state", 32'(State), 32'd0);
        check("midreset_mov", 32'(MOV), 32'd0);
        check("midreset_traps", 32'({Illegal_Instr, Bus_Error}), 32'd0);
        #1 Reset_n = 1'b1;
        tick;
        run_instr(7, 1'b0, TO, TO);

        // Randomised program
        for (int n = 0; n < 200; n++) begin
            r    = int'($urandom_range(0, 9));
            cond = 1'($urandom_range(0, 1));
            if (r <= 3) begin
                code = ($urandom_range(0, 14) == 0) ? 6 : int'($urandom_range(17, 30));
            end else if (r == 4) code = 7;
            else if (r == 5) code = 11;
            else if (r == 6 || r == 7) code = 13;
            else if (r == 8) code = bad_codes[$urandom_range(0, 13)];
            else code = int'($urandom_range(31, 127));
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 1)) : 0;
            wm = int'($urandom_range(0, TO + 1));
            run_instr(code, cond, wf, wm);
        end

        @(negedge Clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
